// File: rtl/adc_pkg.sv
// Shared types and constants for the ramp-compare ADC: ramp FSM states and
// the output data width used by the capture stage.
package adc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int ADC_DATA_W = 16;

endpackage

// File: rtl/pwm_core.sv
// PWM period counter with registered duty compare; flags the last clock of
// each period so the ramp controller can step duty on a period boundary.
module pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm,
    output logic                o_period_end
);

    localparam logic [PWM_BITS-1:0] PCNT_MAX = '1;

    logic [PWM_BITS-1:0] r_pcnt;
    logic                r_pwm;

    // Counter wraps naturally at PCNT_MAX; compare is registered so pwm lags pcnt by one clock.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pcnt <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            r_pwm  <= (r_pcnt < i_duty);
        end
    end

    assign o_pwm        = r_pwm;
    assign o_period_end = (r_pcnt == PCNT_MAX);

endmodule

// File: rtl/pwm_ramp_gen.sv
// Duty-cycle ramp generator: holds each duty step for SETTLE_PERIODS PWM
// periods, wraps to zero after MAX_DUTY with a sweep_done pulse.
module pwm_ramp_gen
    import adc_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int SETTLE_PERIODS = 4,
    parameter int STEP           = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    output logic                  pwm_out,
    output logic [ADC_DATA_W-1:0] duty_cycle,
    output logic                  sweep_done,
    output logic                  busy
);

    localparam logic [PWM_BITS-1:0] MAX_DUTY   = '1;
    localparam int                  SCNT_W     = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [SCNT_W-1:0]   SCNT_LAST  = SCNT_W'(SETTLE_PERIODS - 1);
    localparam logic [PWM_BITS:0]   STEP_EXT   = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_EXT    = {1'b0, MAX_DUTY};

    ramp_state_t         r_state;
    ramp_state_t         w_state_nxt;
    logic [PWM_BITS-1:0] r_duty;
    logic [SCNT_W-1:0]   r_scnt;
    logic                r_sweep_done;

    logic                w_busy;
    logic                w_clear;
    logic                w_period_end;
    logic                w_pwm;
    logic [PWM_BITS:0]   w_duty_sum;
    logic [PWM_BITS-1:0] w_duty_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_nxt = RAMP;
            RAMP:    if (!enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Clear covers idle, the disable transition and restart; all three zero pcnt, scnt, duty and pwm.
    always_comb begin
        w_busy  = (r_state == RAMP);
        w_clear = (r_state == IDLE) || !enable || restart;
    end

    // Widen by one bit so a large STEP cannot wrap before the clamp.
    always_comb begin
        w_duty_sum = {1'b0, r_duty} + STEP_EXT;
        w_duty_adv = w_duty_sum[PWM_BITS-1:0];
        if (w_duty_sum > MAX_EXT) begin
            w_duty_adv = MAX_DUTY;
        end
    end

    pwm_core #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_core (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_duty       (r_duty),
        .o_pwm        (w_pwm),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_duty       <= '0;
            r_scnt       <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (w_period_end) begin
                if (r_scnt < SCNT_LAST) begin
                    r_scnt <= r_scnt + 1'b1;
                end else begin
                    r_scnt <= '0;
                    if (r_duty == MAX_DUTY) begin
                        r_duty       <= '0;
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_duty <= w_duty_adv;
                    end
                end
            end
        end
    end

    assign pwm_out    = w_pwm;
    assign duty_cycle = ADC_DATA_W'(r_duty);
    assign sweep_done = r_sweep_done;
    assign busy       = w_busy;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Directed bench for pwm_ramp_gen: a STEP=1 instance and a STEP=4 instance,
// both PWM_BITS=4 and SETTLE_PERIODS=2 (one duty step every 32 clocks).
module tb_pwm_ramp_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en1, rs1, en4, rs4;
    logic        pwm1, sweep1, busy1;
    logic        pwm4, sweep4, busy4;
    logic [15:0] duty1, duty4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc1     = 0;
    int cyc4     = 0;
    int sw1      = 0;
    int sw4      = 0;
    int tbl4 [6] = '{0, 4, 8, 12, 15, 0};

    always #5 clk = ~clk;

    pwm_ramp_gen #(.PWM_BITS(4), .SETTLE_PERIODS(2), .STEP(1)) dut (
        .clk(clk), .reset(reset), .enable(en1), .restart(rs1),
        .pwm_out(pwm1), .duty_cycle(duty1), .sweep_done(sweep1), .busy(busy1)
    );

    pwm_ramp_gen #(.PWM_BITS(4), .SETTLE_PERIODS(2), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .restart(rs4),
        .pwm_out(pwm4), .duty_cycle(duty4), .sweep_done(sweep4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc1++;
        cyc4++;
        if (sweep1) sw1++;
        if (sweep4) sw4++;
    endtask

    task automatic run1_to(input int n);
        while (cyc1 < n) tick();
    endtask

    task automatic run4_to(input int n);
        while (cyc4 < n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; en1 = 1'b0; rs1 = 1'b0; en4 = 1'b0; rs4 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (pwm1 !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm1); else n_pass++;
        n_checks++; if (duty1 !== 16'd0) $display("FAIL reset_duty: got %0d want 0", duty1); else n_pass++;
        n_checks++; if (sweep1 !== 1'b0) $display("FAIL reset_sweep: got %b want 0", sweep1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1); else n_pass++;
        n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b want 0", busy4); else n_pass++;
        rs1 = 1'b1;
        repeat (4) tick();
        n_checks++; if (busy1 !== 1'b0) $display("FAIL idle_restart_busy: got %b want 0", busy1); else n_pass++;
        n_checks++; if (duty1 !== 16'd0 || pwm1 !== 1'b0 || sweep1 !== 1'b0)
            $display("FAIL idle_restart_out: got duty=%0d pwm=%b sweep=%b want 0/0/0", duty1, pwm1, sweep1);
        else n_pass++;
        rs1 = 1'b0;
    endtask

    task automatic test_ramp_steps();
        en1 = 1'b1;
        tick();
        cyc1 = 0;
        n_checks++; if (busy1 !== 1'b1) $display("FAIL enable_busy: got %b want 1", busy1); else n_pass++;
        n_checks++; if (duty1 !== 16'd0 || pwm1 !== 1'b0) $display("FAIL enable_start: got duty=%0d pwm=%b want 0/0", duty1, pwm1); else n_pass++;
        run1_to(31);
        n_checks++; if (duty1 !== 16'd0) $display("FAIL step0_hold: got %0d want 0", duty1); else n_pass++;
        run1_to(32);
        n_checks++; if (duty1 !== 16'd1) $display("FAIL step1: got %0d want 1", duty1); else n_pass++;
        run1_to(63);
        n_checks++; if (duty1 !== 16'd1) $display("FAIL step1_hold: got %0d want 1", duty1); else n_pass++;
        run1_to(64);
        n_checks++; if (duty1 !== 16'd2) $display("FAIL step2: got %0d want 2", duty1); else n_pass++;
        run1_to(96);
        n_checks++; if (duty1 !== 16'd3) $display("FAIL step3: got %0d want 3", duty1); else n_pass++;
        // pwm at cycle 97+i reflects pcnt=i of the duty-3 period
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (pwm1 !== (i < 3)) $display("FAIL duty3_pwm[%0d]: got %b want %b", i, pwm1, (i < 3));
            else n_pass++;
        end
    endtask

    task automatic test_full_sweep();
        run1_to(479);
        n_checks++; if (duty1 !== 16'd14) $display("FAIL sweep_479: got %0d want 14", duty1); else n_pass++;
        run1_to(480);
        n_checks++; if (duty1 !== 16'd15) $display("FAIL sweep_480: got %0d want 15", duty1); else n_pass++;
        run1_to(511);
        n_checks++; if (duty1 !== 16'd15 || sweep1 !== 1'b0) $display("FAIL sweep_511: got duty=%0d sweep=%b want 15/0", duty1, sweep1); else n_pass++;
        run1_to(512);
        n_checks++; if (duty1 !== 16'd0 || sweep1 !== 1'b1) $display("FAIL sweep_512: got duty=%0d sweep=%b want 0/1", duty1, sweep1); else n_pass++;
        run1_to(513);
        n_checks++; if (sweep1 !== 1'b0) $display("FAIL sweep_pulse_len: got %b want 0", sweep1); else n_pass++;
        n_checks++; if (sw1 !== 1) $display("FAIL sweep_count: got %0d want 1", sw1); else n_pass++;
        run1_to(543);
        n_checks++; if (duty1 !== 16'd0) $display("FAIL sweep2_hold: got %0d want 0", duty1); else n_pass++;
        run1_to(544);
        n_checks++; if (duty1 !== 16'd1 || busy1 !== 1'b1) $display("FAIL sweep2_step1: got duty=%0d busy=%b want 1/1", duty1, busy1); else n_pass++;
    endtask

    task automatic test_restart();
        run1_to(742);
        n_checks++; if (duty1 !== 16'd7) $display("FAIL pre_restart: got %0d want 7", duty1); else n_pass++;
        rs1 = 1'b1;
        tick();
        rs1 = 1'b0;
        cyc1 = 0;
        sw1 = 0;
        n_checks++; if (duty1 !== 16'd0 || pwm1 !== 1'b0 || sweep1 !== 1'b0)
            $display("FAIL restart_clear: got duty=%0d pwm=%b sweep=%b want 0/0/0", duty1, pwm1, sweep1);
        else n_pass++;
        run1_to(31);
        n_checks++; if (duty1 !== 16'd0) $display("FAIL restart_hold: got %0d want 0", duty1); else n_pass++;
        run1_to(32);
        n_checks++; if (duty1 !== 16'd1) $display("FAIL restart_step1: got %0d want 1", duty1); else n_pass++;
        run1_to(33);
        n_checks++; if (pwm1 !== 1'b1) $display("FAIL restart_pwm_pcnt0: got %b want 1", pwm1); else n_pass++;
        run1_to(34);
        n_checks++; if (pwm1 !== 1'b0) $display("FAIL restart_pwm_pcnt1: got %b want 0", pwm1); else n_pass++;
        n_checks++; if (sw1 !== 0) $display("FAIL restart_no_sweep: got %0d want 0", sw1); else n_pass++;
    endtask

    task automatic test_disable();
        run1_to(165);
        n_checks++; if (duty1 !== 16'd5) $display("FAIL pre_disable: got %0d want 5", duty1); else n_pass++;
        en1 = 1'b0;
        tick();
        n_checks++; if (busy1 !== 1'b0 || pwm1 !== 1'b0 || duty1 !== 16'd0)
            $display("FAIL disable: got busy=%b pwm=%b duty=%0d want 0/0/0", busy1, pwm1, duty1);
        else n_pass++;
        repeat (3) tick();
        n_checks++; if (busy1 !== 1'b0) $display("FAIL disable_stay: got %b want 0", busy1); else n_pass++;
        en1 = 1'b1;
        tick();
        cyc1 = 0;
        n_checks++; if (busy1 !== 1'b1 || duty1 !== 16'd0) $display("FAIL reenable: got busy=%b duty=%0d want 1/0", busy1, duty1); else n_pass++;
        run1_to(31);
        n_checks++; if (duty1 !== 16'd0) $display("FAIL reenable_hold: got %0d want 0", duty1); else n_pass++;
        run1_to(32);
        n_checks++; if (duty1 !== 16'd1) $display("FAIL reenable_step1: got %0d want 1", duty1); else n_pass++;
        run1_to(33);
        n_checks++; if (pwm1 !== 1'b1) $display("FAIL reenable_pwm_pcnt0: got %b want 1", pwm1); else n_pass++;
        run1_to(34);
        n_checks++; if (pwm1 !== 1'b0) $display("FAIL reenable_pwm_pcnt1: got %b want 0", pwm1); else n_pass++;
    endtask

    task automatic test_step4();
        en4 = 1'b1;
        tick();
        cyc4 = 0;
        sw4 = 0;
        for (int k = 1; k < 6; k++) begin
            run4_to(32 * k - 1);
            n_checks++; if (duty4 !== 16'(tbl4[k-1])) $display("FAIL step4_hold[%0d]: got %0d want %0d", k, duty4, tbl4[k-1]); else n_pass++;
            run4_to(32 * k);
            n_checks++; if (duty4 !== 16'(tbl4[k]) || sweep4 !== (k == 5))
                $display("FAIL step4_adv[%0d]: got duty=%0d sweep=%b want %0d/%b", k, duty4, sweep4, tbl4[k], (k == 5));
            else n_pass++;
        end
        run4_to(319);
        n_checks++; if (duty4 !== 16'd15 || sw4 !== 1) $display("FAIL step4_pre_restart: got duty=%0d sweeps=%0d want 15/1", duty4, sw4); else n_pass++;
        rs4 = 1'b1;
        tick();
        rs4 = 1'b0;
        cyc4 = 0;
        n_checks++; if (duty4 !== 16'd0 || sweep4 !== 1'b0) $display("FAIL step4_restart_wrap: got duty=%0d sweep=%b want 0/0", duty4, sweep4); else n_pass++;
        run4_to(32);
        n_checks++; if (duty4 !== 16'd4 || sw4 !== 1) $display("FAIL step4_after_restart: got duty=%0d sweeps=%0d want 4/1", duty4, sw4); else n_pass++;
    endtask

    task automatic test_reset_mid_ramp();
        run1_to(511);
        n_checks++; if (duty1 !== 16'd15) $display("FAIL pre_reset_mid: got %0d want 15", duty1); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (busy1 !== 1'b0 || duty1 !== 16'd0 || pwm1 !== 1'b0 || sweep1 !== 1'b0)
            $display("FAIL reset_mid: got busy=%b duty=%0d pwm=%b sweep=%b want 0/0/0/0", busy1, duty1, pwm1, sweep1);
        else n_pass++;
        n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_mid_busy4: got %b want 0", busy4); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (busy1 !== 1'b1 || duty1 !== 16'd0) $display("FAIL reset_mid_resume: got busy=%b duty=%0d want 1/0", busy1, duty1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp_steps();
        test_full_sweep();
        test_restart();
        test_disable();
        test_step4();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
